// File: rtl/decoder_66b_64b.sv
// Purpose : 64b/66b receive block decoder with sync-header block-lock FSM and bit-slip request.
// Latency : 1 cycle from an enable-qualified block to data_bits/control_bits/data_valid/slip/decode_error.
// Backpressure: none; one block per enable cycle, outputs, FSM and counters hold while enable is low.
//
// Ports:
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   enable              block-valid strobe from the descrambler
//   encoded_data[65:0]  [1:0] sync header, [9:2] block type, [65:10] payload
//   data_bits[63:0]     decoded octets, lane n = [8n+7:8n]
//   control_bits[7:0]   per-lane control flag
//   data_valid          registered enable
//   block_lock          high while the lock FSM is LOCKED
//   slip                one-cycle bit-slip request to the gearbox
//   decode_error        one-cycle pulse when the block decoded as an error block
// Build option: define DEC66_LPI_EN to decode the all-LPI control block instead of flagging it.
module decoder_66b_64b #(
    parameter int LOCK_COUNT   = 64,
    parameter int BAD_SH_LIMIT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic [65:0] encoded_data,
    output logic [63:0] data_bits,
    output logic [7:0]  control_bits,
    output logic        data_valid,
    output logic        block_lock,
    output logic        slip,
    output logic        decode_error
);

    localparam int GW = $clog2(LOCK_COUNT) + 1;
    localparam int BW = $clog2(BAD_SH_LIMIT) + 1;

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [GW-1:0] r_good_cnt, w_good_nxt;
    logic [GW-1:0] r_win_cnt, w_win_nxt;
    logic [BW-1:0] r_bad_cnt, w_bad_nxt, w_bad_inc;
    logic        w_slip;

    logic [63:0] r_data;
    logic [7:0]  r_ctl;
    logic        r_vld, r_slip, r_err;

    logic [1:0]  w_hdr;
    logic [7:0]  w_btf;
    logic [55:0] w_pay;
    logic        w_sh_ok;
    logic        w_term;
    logic [3:0]  w_k;
    logic        w_idles_ok;
    logic [63:0] w_dat;
    logic [7:0]  w_ctl;
    logic        w_err;

    assign w_hdr   = encoded_data[1:0];
    assign w_btf   = encoded_data[9:2];
    assign w_pay   = encoded_data[65:10];
    assign w_sh_ok = encoded_data[1] ^ encoded_data[0];

    // True when every 7-bit char of the payload equals c (char j at [7j +: 7]).
    function automatic logic all_chars(input logic [55:0] p, input logic [6:0] c);
        logic r;
        r = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (p[7*j +: 7] != c) r = 1'b0;
        end
        return r;
    endfunction

    // Lock FSM: advances only on enable cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_win_nxt   = r_win_cnt;
        w_bad_nxt   = r_bad_cnt;
        w_slip      = 1'b0;
        w_bad_inc   = r_bad_cnt + {{(BW-1){1'b0}}, ~w_sh_ok};
        if (enable) begin
            case (r_state)
                HUNT: begin
                    if (w_sh_ok) begin
                        if (r_good_cnt == GW'(LOCK_COUNT - 1)) begin
                            w_state_nxt = LOCKED;
                            w_good_nxt  = '0;
                            w_win_nxt   = '0;
                            w_bad_nxt   = '0;
                        end else begin
                            w_good_nxt = r_good_cnt + 1'b1;
                        end
                    end else begin
                        w_slip     = 1'b1;
                        w_good_nxt = '0;
                    end
                end
                LOCKED: begin
                    // Loss of lock is checked before the window wrap so it wins on the last block.
                    if (w_bad_inc == BW'(BAD_SH_LIMIT)) begin
                        w_state_nxt = HUNT;
                        w_slip      = 1'b1;
                        w_good_nxt  = '0;
                        w_win_nxt   = '0;
                        w_bad_nxt   = '0;
                    end else if (r_win_cnt == GW'(LOCK_COUNT - 1)) begin
                        w_win_nxt = '0;
                        w_bad_nxt = '0;
                    end else begin
                        w_win_nxt = r_win_cnt + 1'b1;
                        w_bad_nxt = w_bad_inc;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // Terminate block types: k = number of data octets ahead of the terminate lane.
    always_comb begin
        w_term = 1'b1;
        w_k    = 4'd0;
        case (w_btf)
            8'h87:   w_k = 4'd0;
            8'h99:   w_k = 4'd1;
            8'haa:   w_k = 4'd2;
            8'hb4:   w_k = 4'd3;
            8'hcc:   w_k = 4'd4;
            8'hd2:   w_k = 4'd5;
            8'he1:   w_k = 4'd6;
            8'hff:   w_k = 4'd7;
            default: w_term = 1'b0;
        endcase
    end

    // Idle chars sit in the top of the payload, char j at [7j +: 7]; pad bits between
    // the data octets and the first idle char are don't-care.
    always_comb begin
        w_idles_ok = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if ((4'(j) > w_k) && (w_pay[7*j +: 7] != 7'h00)) w_idles_ok = 1'b0;
        end
    end

    // Block decode; anything not matched below stays an error block.
    always_comb begin
        w_dat = {8{8'hfe}};
        w_ctl = 8'hff;
        w_err = 1'b1;
        if (r_state == LOCKED) begin
            if (w_hdr == 2'b10) begin
                w_dat = encoded_data[65:2];
                w_ctl = 8'h00;
                w_err = 1'b0;
            end else if (w_hdr == 2'b01) begin
                if (w_btf == 8'h1e) begin
                    if (all_chars(w_pay, 7'h00)) begin
                        w_dat = {8{8'h07}};
                        w_err = 1'b0;
                    end else if (all_chars(w_pay, 7'h1e)) begin
                        w_err = 1'b0;
`ifdef DEC66_LPI_EN
                    end else if (all_chars(w_pay, 7'h06)) begin
                        w_dat = {8{8'h06}};
                        w_err = 1'b0;
`endif
                    end
                end else if (w_btf == 8'h78) begin
                    w_dat = {w_pay, 8'hfb};
                    w_ctl = 8'h01;
                    w_err = 1'b0;
                end else if (w_term && w_idles_ok) begin
                    w_err = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        if (4'(i) < w_k) begin
                            w_dat[8*i +: 8] = w_pay[8*i +: 8];
                            w_ctl[i]        = 1'b0;
                        end else if (4'(i) == w_k) begin
                            w_dat[8*i +: 8] = 8'hfd;
                        end else begin
                            w_dat[8*i +: 8] = 8'h07;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= HUNT;
            r_good_cnt <= '0;
            r_win_cnt  <= '0;
            r_bad_cnt  <= '0;
            r_data     <= '0;
            r_ctl      <= '0;
            r_vld      <= 1'b0;
            r_slip     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
            r_win_cnt  <= w_win_nxt;
            r_bad_cnt  <= w_bad_nxt;
            r_vld      <= enable;
            r_slip     <= w_slip;
            r_err      <= enable & w_err;
            if (enable) begin
                r_data <= w_dat;
                r_ctl  <= w_ctl;
            end
        end
    end

    assign data_bits    = r_data;
    assign control_bits = r_ctl;
    assign data_valid   = r_vld;
    assign block_lock   = (r_state == LOCKED);
    assign slip         = r_slip;
    assign decode_error = r_err;

endmodule

// File: tb/tb_decoder_66b_64b.sv
// Purpose : self-checking bench for decoder_66b_64b against a lane-level reference model.
// Latency : model outputs become visible one edge after the block is driven.
// Backpressure: none; the bench drives enable directly, with random idle cycles.
module tb_decoder_66b_64b;

    logic        CLK = 1'b0;
    logic        RST;
    logic        enable;
    logic [65:0] encoded_data;
    logic [63:0] data_bits;
    logic [7:0]  control_bits;
    logic        data_valid, block_lock, slip, decode_error;

    always #5 CLK = ~CLK;

    decoder_66b_64b dut (
        .CLK          (CLK),
        .RST          (RST),
        .enable       (enable),
        .encoded_data (encoded_data),
        .data_bits    (data_bits),
        .control_bits (control_bits),
        .data_valid   (data_valid),
        .block_lock   (block_lock),
        .slip         (slip),
        .decode_error (decode_error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state, kept as plain integers.
    bit          m_locked;
    int          m_good, m_win, m_bad;
    logic [63:0] m_data;
    logic [7:0]  m_ctrl;
    bit          m_vld, m_slip, m_err;

    function automatic int term_k(input logic [7:0] btf);
        case (btf)
            8'h87: return 0;
            8'h99: return 1;
            8'haa: return 2;
            8'hb4: return 3;
            8'hcc: return 4;
            8'hd2: return 5;
            8'he1: return 6;
            8'hff: return 7;
            default: return -1;
        endcase
    endfunction

    function automatic void ref_decode(input logic [65:0] b, input bit locked,
                                       output logic [63:0] d, output logic [7:0] c, output bit e);
        logic [55:0] p;
        logic [6:0]  ch [8];
        int n_idle, n_errc, n_lpi, k;
        p = b[65:10];
        d = {8{8'hfe}};
        c = 8'hff;
        e = 1'b1;
        n_idle = 0; n_errc = 0; n_lpi = 0;
        for (int j = 0; j < 8; j++) begin
            ch[j] = p[7*j +: 7];
            if (ch[j] == 7'h00) n_idle++;
            if (ch[j] == 7'h1e) n_errc++;
            if (ch[j] == 7'h06) n_lpi++;
        end
        if (!locked) return;
        if (b[1:0] == 2'b10) begin
            d = b[65:2]; c = 8'h00; e = 1'b0;
            return;
        end
        if (b[1:0] != 2'b01) return;
        if (b[9:2] == 8'h1e) begin
            if (n_idle == 8) begin d = {8{8'h07}}; e = 1'b0; end
            else if (n_errc == 8) e = 1'b0;
`ifdef DEC66_LPI_EN
            else if (n_lpi == 8) begin d = {8{8'h06}}; e = 1'b0; end
`endif
            return;
        end
        if (b[9:2] == 8'h78) begin
            d = {p, 8'hfb}; c = 8'h01; e = 1'b0;
            return;
        end
        k = term_k(b[9:2]);
        if (k < 0) return;
        for (int j = k + 1; j < 8; j++) if (ch[j] != 7'h00) return;
        e = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < k)       begin d[8*i +: 8] = p[8*i +: 8]; c[i] = 1'b0; end
            else if (i == k) begin d[8*i +: 8] = 8'hfd;       c[i] = 1'b1; end
            else             begin d[8*i +: 8] = 8'h07;       c[i] = 1'b1; end
        end
    endfunction

    task automatic model_step(input logic rst, input logic en, input logic [65:0] blk);
        logic [63:0] d;
        logic [7:0]  c;
        bit          e, ok;
        if (rst) begin
            m_locked = 0; m_good = 0; m_win = 0; m_bad = 0;
            m_data = '0; m_ctrl = '0; m_vld = 0; m_slip = 0; m_err = 0;
            return;
        end
        m_vld = en; m_slip = 0; m_err = 0;
        if (!en) return;
        ref_decode(blk, m_locked, d, c, e);
        m_data = d; m_ctrl = c; m_err = e;
        ok = (blk[1:0] == 2'b01) || (blk[1:0] == 2'b10);
        if (!m_locked) begin
            if (ok) begin
                m_good++;
                if (m_good == 64) begin m_locked = 1; m_good = 0; m_win = 0; m_bad = 0; end
            end else begin
                m_slip = 1; m_good = 0;
            end
        end else begin
            m_win++;
            if (!ok) m_bad++;
            if (m_bad == 16) begin
                m_locked = 0; m_slip = 1; m_good = 0; m_win = 0; m_bad = 0;
            end else if (m_win == 64) begin
                m_win = 0; m_bad = 0;
            end
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [65:0] blk);
        @(negedge CLK);
        RST = rst; enable = en; encoded_data = blk;
        model_step(rst, en, blk);
        @(posedge CLK);
        #1;
        chk("data_bits",    data_bits,    m_data);
        chk("control_bits", 64'(control_bits), 64'(m_ctrl));
        chk("data_valid",   64'(data_valid),   64'(m_vld));
        chk("block_lock",   64'(block_lock),   64'(m_locked));
        chk("slip",         64'(slip),         64'(m_slip));
        chk("decode_error", 64'(decode_error), 64'(m_err));
    endtask

    function automatic logic [65:0] data_blk(input logic [63:0] v);
        return {v, 2'b10};
    endfunction

    function automatic logic [65:0] ctl_blk(input logic [7:0] btf, input logic [55:0] p);
        return {p, btf, 2'b01};
    endfunction

    // Random terminate block with k data octets, random pad, zero idle chars above.
    function automatic logic [65:0] term_blk(input int k, input logic [55:0] rnd);
        logic [55:0] p;
        logic [7:0]  btfs [8];
        btfs = '{8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff};
        p = rnd;
        for (int j = k + 1; j < 8; j++) p[7*j +: 7] = 7'h00;
        return ctl_blk(btfs[k], p);
    endfunction

    function automatic logic [65:0] rand_blk(input int bad_rate);
        logic [95:0] r;
        int kind;
        r = {$urandom(), $urandom(), $urandom()};
        if ($urandom_range(0, bad_rate - 1) == 0)
            return {r[63:0], ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11};
        kind = $urandom_range(0, 9);
        case (kind)
            0, 1, 2: return data_blk(r[63:0]);
            3:       return ctl_blk(8'h1e, 56'h0);
            4:       return ctl_blk(8'h1e, {8{7'h1e}});
            5:       return ctl_blk(8'h78, r[55:0]);
            6, 7:    return term_blk($urandom_range(0, 7), r[55:0]);
            8:       return ctl_blk(r[7:0], r[63:8]);
            default: return ctl_blk(8'h87, r[55:0]);
        endcase
    endfunction

    localparam logic [63:0] PAT = 64'h0123456789abcdef;

    initial begin
        RST = 1'b1; enable = 1'b0; encoded_data = '0;
        step(1, 0, '0);
        step(1, 0, '0);
        chk("reset_lock", 64'(block_lock), 64'd0);

        // Acquire lock with 64 data blocks; the 64th is still an error block.
        for (int i = 0; i < 64; i++) step(0, 1, data_blk(PAT));
        chk("lock_after_64", 64'(block_lock), 64'd1);
        chk("lock_block_err", 64'(decode_error), 64'd1);
        step(0, 1, data_blk(PAT));
        chk("blk65_data", data_bits, PAT);
        chk("blk65_ctrl", 64'(control_bits), 64'h00);

        step(0, 1, ctl_blk(8'h78, 56'h11223344556677));
        chk("start_data", data_bits, 64'h11223344556677fb);
        chk("start_ctrl", 64'(control_bits), 64'h01);
        step(0, 1, ctl_blk(8'hcc, 56'h000000deadbeef));
        chk("term4_data", data_bits, 64'h070707fddeadbeef);
        chk("term4_ctrl", 64'(control_bits), 64'hf0);

        step(0, 1, ctl_blk(8'h1e, {8{7'h06}}));
`ifdef DEC66_LPI_EN
        chk("lpi_data", data_bits, {8{8'h06}});
        chk("lpi_err", 64'(decode_error), 64'd0);
`else
        chk("lpi_data", data_bits, {8{8'hfe}});
        chk("lpi_err", 64'(decode_error), 64'd1);
`endif
        step(0, 1, ctl_blk(8'h00, 56'h0));
        chk("btf00_err", 64'(decode_error), 64'd1);
        step(0, 1, ctl_blk(8'h99, {{6{7'h00}}, 6'h0, 8'h5a} | 56'h1 << 20));
        chk("bad_idle_err", 64'(decode_error), 64'd1);

        // Align to a window start, then 15 bad headers per window over three windows.
        for (int g = 0; g < 64 && m_win != 0; g++) step(0, 1, data_blk(PAT));
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < 64; i++)
                step(0, 1, (i < 15) ? {PAT, 2'b11} : data_blk(PAT));
        chk("hold_lock_15bad", 64'(block_lock), 64'd1);

        // 16 bad headers in one window drop lock with a slip.
        for (int i = 0; i < 16; i++) step(0, 1, {PAT, 2'b00});
        chk("drop_lock", 64'(block_lock), 64'd0);
        chk("drop_slip", 64'(slip), 64'd1);

        // HUNT: a bad header restarts the good-header count.
        for (int i = 0; i < 10; i++) step(0, 1, data_blk(PAT));
        step(0, 1, {PAT, 2'b11});
        chk("hunt_slip", 64'(slip), 64'd1);
        step(0, 1, data_blk(PAT));
        chk("hunt_slip_once", 64'(slip), 64'd0);
        for (int i = 0; i < 62; i++) step(0, 1, data_blk(PAT));
        chk("hunt_not_yet", 64'(block_lock), 64'd0);
        step(0, 1, data_blk(PAT));
        chk("hunt_relock", 64'(block_lock), 64'd1);

        // Random traffic: mostly clean, then noisy enough to lose lock.
        for (int i = 0; i < 600; i++)
            step(0, ($urandom_range(0, 7) != 0), rand_blk(25));
        for (int i = 0; i < 200; i++)
            step(0, ($urandom_range(0, 5) != 0), rand_blk(3));
        for (int i = 0; i < 64; i++) step(0, 1, data_blk(PAT));
        for (int i = 0; i < 100; i++)
            step(0, ($urandom_range(0, 7) != 0), rand_blk(25));

        // Reset while locked and enabled.
        for (int i = 0; i < 64 && !m_locked; i++) step(0, 1, data_blk(PAT));
        step(1, 1, data_blk(PAT));
        chk("rst_lock", 64'(block_lock), 64'd0);
        chk("rst_data", data_bits, 64'd0);
        chk("rst_valid", 64'(data_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
